// File: rtl/led_fade_scheduler.sv
`default_nettype none
// ============================================================================
// led_fade_scheduler: NUM_CH breathing-LED channels sharing one step prescaler.
// Optional macro LED_FADE_GAMMA_EN squares intensity for the PWM level. Rev 1.0
// ============================================================================
module led_fade_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 3,
  parameter int TICK_DIV   = 50000000,
  parameter int HOLD_STEPS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] busy,
  output logic              tick
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [WIDTH-1:0]  c_max       = '1;
  localparam logic [CNT_W-1:0]  c_tick_last = CNT_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_STEPS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    UP        = 3'd1,
    HIGH_HOLD = 3'd2,
    DOWN      = 3'd3,
    LOW_HOLD  = 3'd4
  } state_t;

  logic [CNT_W-1:0] r_presc;
  logic             r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick  <= (r_presc == c_tick_last);
      r_presc <= (r_presc == c_tick_last) ? '0 : r_presc + CNT_W'(1);
    end
  end

  assign tick = r_tick;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_int, w_int_nxt, r_acc, w_level;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic              r_pend, w_pend_nxt, w_pend_eff;
    logic              r_led, r_busy;
    logic [WIDTH:0]    w_sum;

`ifdef LED_FADE_GAMMA_EN
    logic [2*WIDTH-1:0] w_sq;
    assign w_sq    = {{WIDTH{1'b0}}, r_int} * {{WIDTH{1'b0}}, r_int};
    assign w_level = WIDTH'(w_sq >> WIDTH);
`else
    assign w_level = r_int;
`endif

    // First-order sigma-delta: the carry out of acc + level is the LED bit.
    assign w_sum = {1'b0, r_acc} + {1'b0, w_level};

    always_comb begin
      w_state_nxt = r_state;
      w_int_nxt   = r_int;
      w_hold_nxt  = r_hold;
      // A stop seen on a tick cycle must act on that same tick.
      w_pend_eff  = r_pend | stop[g];
      w_pend_nxt  = (r_state == IDLE) ? 1'b0 : w_pend_eff;
      case (r_state)
        IDLE: begin
          if (start[g] && !stop[g]) begin
            w_state_nxt = UP;
            w_int_nxt   = '0;
          end
        end
        UP: begin
          if (r_tick) begin
            if (w_pend_eff) begin
              w_state_nxt = DOWN;
            end else if (r_int == c_max) begin
              w_state_nxt = HIGH_HOLD;
              w_hold_nxt  = '0;
            end else begin
              w_int_nxt = r_int + WIDTH'(1);
            end
          end
        end
        HIGH_HOLD: begin
          if (r_tick) begin
            if (w_pend_eff || (r_hold == c_hold_last)) begin
              w_state_nxt = DOWN;
            end else begin
              w_hold_nxt = r_hold + HOLD_W'(1);
            end
          end
        end
        DOWN: begin
          if (r_tick) begin
            if (r_int == '0) begin
              if (w_pend_eff) begin
                w_state_nxt = IDLE;
              end else begin
                w_state_nxt = LOW_HOLD;
                w_hold_nxt  = '0;
              end
            end else begin
              w_int_nxt = r_int - WIDTH'(1);
            end
          end
        end
        LOW_HOLD: begin
          if (r_tick) begin
            if (r_hold == c_hold_last) begin
              w_state_nxt = w_pend_eff ? IDLE : UP;
            end else begin
              w_hold_nxt = r_hold + HOLD_W'(1);
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      if (w_state_nxt == IDLE) w_pend_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= IDLE;
        r_int   <= '0;
        r_hold  <= '0;
        r_pend  <= 1'b0;
        r_acc   <= '0;
        r_led   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_int   <= w_int_nxt;
        r_hold  <= w_hold_nxt;
        r_pend  <= w_pend_nxt;
        r_busy  <= (w_state_nxt != IDLE);
        if (r_state == IDLE) begin
          r_acc <= '0;
          r_led <= 1'b0;
        end else begin
          r_acc <= w_sum[WIDTH-1:0];
          r_led <= w_sum[WIDTH];
        end
      end
    end

    assign led[g]  = r_led;
    assign busy[g] = r_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_led_fade_scheduler.sv
`default_nettype none
// tb_led_fade_scheduler: directed and random stimulus against a waveform-position
// reference model of the breathing controller (2 channels, 3-bit, tick every 4).
module tb_led_fade_scheduler;

  localparam int NUM_CH     = 2;
  localparam int WIDTH      = 3;
  localparam int TICK_DIV   = 4;
  localparam int HOLD_STEPS = 2;
  localparam int STEPS      = 1 << WIDTH;
  localparam int MAXI       = STEPS - 1;
  localparam int PERIOD     = 2 * STEPS + 2 * HOLD_STEPS;
  localparam int DOWN0      = STEPS + HOLD_STEPS;
  localparam int DOWN_END   = DOWN0 + MAXI;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] start, stop;
  logic [NUM_CH-1:0] led, busy;
  logic              tick;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: each active channel sits at a position along one breathing period.
  bit m_act  [NUM_CH];
  int m_pos  [NUM_CH];
  bit m_pend [NUM_CH];
  int m_sum  [NUM_CH];
  bit m_led  [NUM_CH];
  int edges;
  bit m_tick;

  led_fade_scheduler #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .HOLD_STEPS(HOLD_STEPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .led(led), .busy(busy), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int level_of(input int i);
`ifdef LED_FADE_GAMMA_EN
    return (i * i) >> WIDTH;
`else
    return i;
`endif
  endfunction

  function automatic int int_of(input int p);
    if (p < STEPS) return p;
    if (p < DOWN0) return MAXI;
    if (p <= DOWN_END) return DOWN_END - p;
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_act[c] = 0; m_pos[c] = 0; m_pend[c] = 0; m_sum[c] = 0; m_led[c] = 0;
    end
    edges  = 0;
    m_tick = 0;
  endtask

  // Advance the model over one clock edge, let the DUT take the edge, compare.
  task automatic step();
    for (int c = 0; c < NUM_CH; c++) begin
      if (!m_act[c]) begin
        m_led[c] = 0;
        m_sum[c] = 0;
        if (start[c] && !stop[c]) begin
          m_act[c] = 1; m_pos[c] = 0; m_pend[c] = 0;
        end
      end else begin
        int lvl;
        lvl      = level_of(int_of(m_pos[c]));
        m_led[c] = ((m_sum[c] + lvl) / STEPS) != (m_sum[c] / STEPS);
        m_sum[c] += lvl;
        if (stop[c]) m_pend[c] = 1;
        if (m_tick) begin
          if (!m_pend[c]) m_pos[c] = (m_pos[c] + 1) % PERIOD;
          else if (m_pos[c] < DOWN0) m_pos[c] = DOWN_END - int_of(m_pos[c]);
          else if (m_pos[c] == DOWN_END || m_pos[c] == PERIOD - 1) begin
            m_act[c] = 0; m_pend[c] = 0;
          end else m_pos[c]++;
        end
      end
    end
    edges++;
    m_tick = (edges % TICK_DIV) == 0;
    @(posedge clk);
    #1;
    check("tick", tick, m_tick);
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("busy%0d", c), busy[c], m_act[c]);
      check($sformatf("led%0d", c), led[c], m_led[c]);
    end
  endtask

  task automatic wait_pos(input int c, input int p, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (m_act[c] && m_pos[c] == p) found = 1;
      else step();
    end
    n_checks++;
    assert (found) n_pass++;
    else $error("FAIL wait_pos ch%0d observed=expired expected=pos %0d", c, p);
  endtask

  task automatic wait_idle(input int c, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (!m_act[c]) found = 1;
      else step();
    end
    n_checks++;
    assert (found) n_pass++;
    else $error("FAIL wait_idle ch%0d observed=expired expected=idle", c);
  endtask

  initial begin
    int hi, nt;
    rst_n = 1'b1; start = '0; stop = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    check("rst_tick", tick, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_led", led, 0);
    check("rst_hold_busy", busy, 0);
    check("rst_hold_tick", tick, 0);
    rst_n = 1'b1;
    model_reset();
    repeat (12) step();

    // Full breathing cycle on ch0 with duty checks in both holds
    start = 2'b01; step(); start = '0;
    check("busy0_after_start", busy[0], 1);
    wait_pos(0, STEPS, 200);
    hi = 0;
    repeat (8) begin step(); hi += int'(led[0]); end
    check("high_hold_duty", hi, level_of(MAXI));
    wait_pos(0, DOWN_END + 1, 200);
    hi = 0;
    repeat (8) begin step(); hi += int'(led[0]); end
    check("low_hold_duty", hi, 0);

    // Graceful stop from UP at intensity 3
    wait_pos(0, 3, 200);
    nt = 0;
    stop = 2'b01; nt += int'(tick); step(); stop = '0;
    for (int i = 0; i < 100 && busy[0]; i++) begin nt += int'(tick); step(); end
    check("stop_busy_fall", busy[0], 0);
    check("stop_tick_count", nt, 5);

    // ch1 started while ch0 ramps down
    start = 2'b01; step(); start = '0;
    wait_pos(0, DOWN0 + 2, 200);
    start = 2'b10; step(); start = '0;
    check("busy1_started", busy[1], 1);
    check("busy0_unaffected", busy[0], 1);
    repeat (60) step();

    // start and stop together in IDLE: ignored
    stop = 2'b10; step(); stop = '0;
    wait_idle(1, 200);
    start = 2'b10; stop = 2'b10; step(); start = '0; stop = '0;
    check("collide_busy1", busy[1], 0);
    step();
    check("collide_busy1_later", busy[1], 0);

    // start while busy: ignored
    start = 2'b01; step(); start = '0;
    repeat (20) step();

    // Asynchronous reset during HIGH_HOLD
    wait_pos(0, STEPS + 1, 200);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_led0", led[0], 0);
    check("midrst_busy0", busy[0], 0);
    check("midrst_tick", tick, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (12) step();
    check("after_rst_idle", busy[0], 0);

    // Random start/stop traffic
    repeat (800) begin
      for (int c = 0; c < NUM_CH; c++) begin
        start[c] = ($urandom_range(0, 15) == 0);
        stop[c]  = ($urandom_range(0, 60) == 0);
      end
      step();
    end
    start = '0; stop = '0;
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_fade_scheduler.md
# led_fade_scheduler

Multi-channel LED breathing controller. Drives NUM_CH independent fade sequences from one shared step-rate prescaler. Each channel runs its own ramp-up / hold / ramp-down / hold state machine, and its own first-order PWM accumulator produces the LED output. It sits between board-level start/stop controls (buttons or a host register) and the LED pins. It replaces per-LED free-running fade logic with a single scheduled resource.

## Interface
- NUM_CH, 4: number of LED channels.
- WIDTH, 3: intensity/accumulator width; MAX = 2^WIDTH-1.
- TICK_DIV, 50000000: clk cycles per fade step, ≥2.
- HOLD_STEPS, 2: ticks spent in each hold state, ≥1.
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  NUM_CH  per-channel start request, level-sampled each cycle.
- stop  input  NUM_CH  per-channel graceful-stop request, level-sampled each cycle.
- led  output  NUM_CH  PWM LED drive, registered.
- busy  output  NUM_CH  1 while the channel is not IDLE, registered.
- tick  output  1  one-cycle step strobe shared by all channels.

## Operation
- Prescaler counts 0..TICK_DIV-1 and wraps; tick=1 in the cycle after the count equals TICK_DIV-1. Width is $clog2(TICK_DIV). It free-runs regardless of channel state.
- Per-channel state: IDLE, UP, HIGH_HOLD, DOWN, LOW_HOLD. Each channel also has intensity[WIDTH-1:0], hold_cnt, stop_pending, and acc[WIDTH-1:0].
- IDLE: start=1 → UP next edge, with intensity=0, acc=0, stop_pending=0. If stop=1 in the same cycle, start is ignored.
- All other transitions occur only on tick cycles.
- UP: if intensity==MAX → HIGH_HOLD, hold_cnt=0; else intensity+1.
- HIGH_HOLD: if hold_cnt==HOLD_STEPS-1 → DOWN; else hold_cnt+1.
- DOWN: if intensity==0 → IDLE when stop_pending, else LOW_HOLD with hold_cnt=0; otherwise intensity-1.
- LOW_HOLD: if hold_cnt==HOLD_STEPS-1 → UP, or IDLE when stop_pending; else hold_cnt+1.
- stop=1 in any non-IDLE state sets stop_pending (sticky until IDLE).
  - In UP or HIGH_HOLD with stop_pending set, the next tick goes to DOWN with intensity unchanged.
  - stop asserted on a tick cycle takes effect that same tick.
- start while non-IDLE is ignored. stop in IDLE is ignored.
- PWM: every cycle in non-IDLE states, {led,acc} <= acc + level, where level = intensity. Duty is level/2^WIDTH. In IDLE, led=0 and acc=0.
- Channels are fully independent apart from the shared tick.

## Timing
- Reset values: led=0, busy=0, tick=0, prescaler=0, all states IDLE, intensity=0, acc=0, stop_pending=0.
- Async reset mid-operation forces these values immediately. Operation resumes on the first edge after rst_n rises.
- start → busy=1 one cycle later. First intensity step happens at the next tick, 1..TICK_DIV cycles later depending on prescaler phase.
- Uninterrupted period: (MAX+1) UP ticks + HOLD_STEPS + (MAX+1) DOWN ticks + HOLD_STEPS = 2·2^WIDTH + 2·HOLD_STEPS ticks.
- Entering IDLE: busy and led are 0 from the edge after the transition tick.
- led reflects intensity changes from the following cycle. acc carry semantics: at a constant level, led is high exactly level cycles out of every 2^WIDTH.

## Configuration
- LED_FADE_GAMMA_EN defined: level = (intensity·intensity) >> WIDTH, using a 2·WIDTH-bit product. For WIDTH=3 this gives 0,0,0,1,2,3,4,6 for intensity 0..7. The FSM is unchanged.
- LED_FADE_GAMMA_EN undefined: level = intensity (linear).

## Test plan
All scenarios use NUM_CH=2, WIDTH=3, TICK_DIV=4, HOLD_STEPS=2, linear mode unless noted.
- Reset: rst_n=0 → led=0, busy=0, tick=0; after release, tick pulses every 4 cycles and busy stays 0 with no start.
- Full cycle: start[0] one cycle → busy[0]=1 next cycle. State sequence is UP 8 ticks, HIGH_HOLD 2, DOWN 8, LOW_HOLD 2, then UP again, for a 20-tick (80-cycle) period.
- Duty: in HIGH_HOLD (intensity 7), led[0] is high in exactly 7 of every 8 cycles. In LOW_HOLD, led[0]=0 continuously. With LED_FADE_GAMMA_EN, HIGH_HOLD duty is 6/8.
- Graceful stop: stop[0] during UP at intensity 3 → next tick enters DOWN at 3; 3 decrement ticks reach 0; the next tick goes to IDLE and busy[0]=0 on the following edge.
- Independence and collisions:
  - start[1] while ch0 is in DOWN → ch1 ramps from 0 and ch0 is unaffected.
  - start[1] and stop[1] together in IDLE → ch1 stays IDLE.
  - start[0] while busy → ignored.
- Reset mid-op: rst_n low during ch0 HIGH_HOLD → led[0]=0 and busy[0]=0 immediately. After release, ch0 needs a new start.
